// File: rtl/pc_dump_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_dump_responder: captures performance-counter dump bursts in a buffer |
// | and answers each burst with a one-cycle write response.                 |
// | Revision: 1.0                                                           |
// +--------------------------------------------------------------------------+
module pc_dump_responder #(
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 64,
  parameter int SIZE_WIDTH   = 32,
  parameter int MAX_BEATS    = 8,
  parameter int WORD_WIDTH   = 64,
  parameter int WREADY_STALL = 0
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  aw_valid,
  input  logic [ADDR_WIDTH-1:0]                                 aw_addr,
  input  logic [SIZE_WIDTH-1:0]                                 aw_size,
  output logic                                                  aw_ready,
  input  logic                                                  w_valid,
  input  logic [DATA_WIDTH-1:0]                                 w_data,
  output logic                                                  w_ready,
  output logic                                                  b_valid,
  output logic [1:0]                                            b_resp,
  output logic                                                  cap_valid,
  output logic [ADDR_WIDTH-1:0]                                 cap_base,
  output logic [$clog2(MAX_BEATS):0]                            cap_beats,
  input  logic                                                  cap_clear,
  output logic [31:0]                                           dump_count,
  input  logic [$clog2(MAX_BEATS*(DATA_WIDTH/WORD_WIDTH))-1:0]  rd_idx,
  output logic [WORD_WIDTH-1:0]                                 rd_data
);

  localparam int c_BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int c_WPB            = DATA_WIDTH / WORD_WIDTH;
  localparam int c_CNT_W          = $clog2(MAX_BEATS) + 1;
  localparam int c_IDX_W          = $clog2(MAX_BEATS * c_WPB);
  localparam int c_BUF_AW         = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [31:0] c_STALL_RELOAD = 32'(WREADY_STALL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_STALL = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SIZE_WIDTH-1:0]   r_beat_idx;
  logic [SIZE_WIDTH-1:0]   r_exp_beats;
  logic                    r_err;
  logic [31:0]             r_stall_cnt;
  logic [DATA_WIDTH-1:0]   r_buf [MAX_BEATS];

  logic [SIZE_WIDTH-1:0]   w_size_rem;
  logic [SIZE_WIDTH-1:0]   w_exp_beats;
  logic                    w_err;
  logic                    w_beat;
  logic                    w_last;
  logic [c_IDX_W-1:0]      w_rd_beat;
  logic [c_IDX_W-1:0]      w_rd_word;
  logic                    w_rd_hit;
  logic [DATA_WIDTH-1:0]   w_rd_line;

  // Ceiling division done as quotient plus a remainder flag so huge sizes cannot overflow.
  assign w_size_rem  = aw_size % SIZE_WIDTH'(c_BYTES_PER_BEAT);
  assign w_exp_beats = (aw_size / SIZE_WIDTH'(c_BYTES_PER_BEAT)) + SIZE_WIDTH'(w_size_rem != '0);
  assign w_err       = (aw_size == '0) || (w_size_rem != '0) ||
                       (w_exp_beats > SIZE_WIDTH'(MAX_BEATS));

  assign w_beat = (r_state == S_DATA) && w_valid;
  assign w_last = w_beat && (r_beat_idx == (r_exp_beats - SIZE_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    aw_ready    = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    b_resp      = 2'b00;
    case (r_state)
      S_IDLE: begin
        aw_ready = !reset;
        if (aw_valid) w_state_nxt = (aw_size == '0) ? S_RESP : S_DATA;
      end
      S_DATA: begin
        w_ready = 1'b1;
        if (w_beat) begin
          if (w_last)                w_state_nxt = S_RESP;
          else if (WREADY_STALL > 0) w_state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (r_stall_cnt == '0) w_state_nxt = S_DATA;
      end
      S_RESP: begin
        b_valid     = 1'b1;
        b_resp      = r_err ? 2'b10 : 2'b00;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_idx  <= '0;
      r_exp_beats <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
      cap_valid   <= 1'b0;
      cap_base    <= '0;
      cap_beats   <= '0;
      dump_count  <= '0;
    end else begin
      // Clear first so the completion set in RESP overrides a coincident clear.
      if (cap_clear) cap_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (aw_valid) begin
            cap_base    <= aw_addr;
            cap_valid   <= 1'b0;
            r_beat_idx  <= '0;
            r_exp_beats <= w_exp_beats;
            r_err       <= w_err;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_beat_idx  <= r_beat_idx + SIZE_WIDTH'(1);
            r_stall_cnt <= c_STALL_RELOAD;
          end
        end
        S_STALL: begin
          if (r_stall_cnt != '0) r_stall_cnt <= r_stall_cnt - 32'd1;
        end
        S_RESP: begin
          cap_valid  <= 1'b1;
          cap_beats  <= (r_exp_beats > SIZE_WIDTH'(MAX_BEATS)) ? c_CNT_W'(MAX_BEATS)
                                                               : c_CNT_W'(r_exp_beats);
          dump_count <= dump_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Overflow beats are accepted but never written.
  always_ff @(posedge clk) begin
    if (w_beat && (r_beat_idx < SIZE_WIDTH'(MAX_BEATS)))
      r_buf[r_beat_idx[c_BUF_AW-1:0]] <= w_data;
  end

  assign w_rd_beat = rd_idx / c_IDX_W'(c_WPB);
  assign w_rd_word = rd_idx % c_IDX_W'(c_WPB);
  assign w_rd_hit  = int'(w_rd_beat) < int'(cap_beats);
  assign w_rd_line = r_buf[w_rd_beat[c_BUF_AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset)         rd_data <= '0;
    else if (w_rd_hit) rd_data <= w_rd_line[int'(w_rd_word)*WORD_WIDTH +: WORD_WIDTH];
    else               rd_data <= '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_dump_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_dump_responder: directed bursts on two responders (no stall and   |
// | two-cycle stall) with a queue-based write-response scoreboard.          |
// | Revision: 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_pc_dump_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         aw_valid   [2];
  logic [63:0]  aw_addr    [2];
  logic [31:0]  aw_size    [2];
  logic         aw_ready   [2];
  logic         w_valid    [2];
  logic [511:0] w_data     [2];
  logic         w_ready    [2];
  logic         b_valid    [2];
  logic [1:0]   b_resp     [2];
  logic         cap_valid  [2];
  logic [63:0]  cap_base   [2];
  logic [3:0]   cap_beats  [2];
  logic         cap_clear  [2];
  logic [31:0]  dump_count [2];
  logic [5:0]   rd_idx     [2];
  logic [63:0]  rd_data    [2];

  pc_dump_responder #(.WREADY_STALL(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .aw_valid(aw_valid[0]), .aw_addr(aw_addr[0]), .aw_size(aw_size[0]), .aw_ready(aw_ready[0]),
    .w_valid(w_valid[0]), .w_data(w_data[0]), .w_ready(w_ready[0]),
    .b_valid(b_valid[0]), .b_resp(b_resp[0]),
    .cap_valid(cap_valid[0]), .cap_base(cap_base[0]), .cap_beats(cap_beats[0]),
    .cap_clear(cap_clear[0]), .dump_count(dump_count[0]),
    .rd_idx(rd_idx[0]), .rd_data(rd_data[0])
  );

  pc_dump_responder #(.WREADY_STALL(2)) u_dut1 (
    .clk(clk), .reset(reset),
    .aw_valid(aw_valid[1]), .aw_addr(aw_addr[1]), .aw_size(aw_size[1]), .aw_ready(aw_ready[1]),
    .w_valid(w_valid[1]), .w_data(w_data[1]), .w_ready(w_ready[1]),
    .b_valid(b_valid[1]), .b_resp(b_resp[1]),
    .cap_valid(cap_valid[1]), .cap_base(cap_base[1]), .cap_beats(cap_beats[1]),
    .cap_clear(cap_clear[1]), .dump_count(dump_count[1]),
    .rd_idx(rd_idx[1]), .rd_data(rd_data[1])
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] resp;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic sb_push(input int u, input logic [1:0] resp, input int at);
    exp_t e;
    e.resp = resp;
    e.cyc  = at;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Word j of beat k is {tag, k, j}; tag 0 reduces to {k, j}.
  function automatic logic [511:0] beat_data(input int tag, input int k);
    logic [511:0] d;
    for (int j = 0; j < 8; j++) d[j*64 +: 64] = {16'(tag), 16'(k), 32'(j)};
    return d;
  endfunction

  always @(negedge clk) begin
    if (b_valid[0] === 1'b1) begin
      if (q0.size() == 0) chk("b_unexpected0", 64'd1, 64'd0);
      else begin
        e0 = q0.pop_front();
        chk("b_resp0", 64'(b_resp[0]), 64'(e0.resp));
        chk("b_cycle0", 64'(cyc), 64'(e0.cyc));
      end
    end
    if (b_valid[1] === 1'b1) begin
      if (q1.size() == 0) chk("b_unexpected1", 64'd1, 64'd0);
      else begin
        e1 = q1.pop_front();
        chk("b_resp1", 64'(b_resp[1]), 64'(e1.resp));
        chk("b_cycle1", 64'(cyc), 64'(e1.cyc));
      end
    end
  end

  // Returns at the negedge following the last beat sent (the RESP cycle of a completed burst).
  task automatic issue(input int u, input logic [63:0] addr, input logic [31:0] size,
                       input int nsend, input int nlast, input logic [1:0] resp,
                       input int tag, input bit gap);
    int t, acc, prev, budget;
    @(negedge clk);
    aw_valid[u] = 1'b1; aw_addr[u] = addr; aw_size[u] = size;
    budget = 0;
    while (aw_ready[u] !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
    if (aw_ready[u] !== 1'b1) begin
      chk("aw_timeout", 64'd0, 64'd1);
      aw_valid[u] = 1'b0;
      return;
    end
    t = cyc;
    if (size == 0) sb_push(u, resp, t + 1);
    @(negedge clk);
    aw_valid[u] = 1'b0;
    chk("w_ready_after_aw", 64'(w_ready[u]), 64'(size != 0));
    prev = 0;
    for (int k = 0; k < nsend; k++) begin
      if (gap && (k % 2 == 1)) begin w_valid[u] = 1'b0; @(negedge clk); end
      w_valid[u] = 1'b1;
      w_data[u]  = beat_data(tag, k);
      budget = 0;
      while (w_ready[u] !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
      if (w_ready[u] !== 1'b1) begin
        chk("w_timeout", 64'd0, 64'd1);
        w_valid[u] = 1'b0;
        return;
      end
      acc = cyc;
      if (u == 0 && !gap && k > 0) chk("back_to_back", 64'(acc), 64'(prev + 1));
      prev = acc;
      if (k == nlast - 1) sb_push(u, resp, acc + 1);
      @(negedge clk);
      w_valid[u] = 1'b0;
      if (u == 1 && k != nlast - 1) begin
        chk("stall_low1", 64'(w_ready[u]), 64'd0);
        @(negedge clk);
        chk("stall_low2", 64'(w_ready[u]), 64'd0);
        @(negedge clk);
        chk("stall_end", 64'(w_ready[u]), 64'd1);
      end
    end
  endtask

  task automatic rd_check(input int u, input logic [5:0] idx, input logic [63:0] req,
                          input string name);
    @(negedge clk);
    rd_idx[u] = idx;
    @(negedge clk);
    chk(name, rd_data[u], req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      aw_valid[u] = 1'b0; aw_addr[u] = '0; aw_size[u] = '0;
      w_valid[u] = 1'b0; w_data[u] = '0; cap_clear[u] = 1'b0; rd_idx[u] = '0;
    end

    repeat (3) @(negedge clk);
    chk("aw_ready_in_reset0", 64'(aw_ready[0]), 64'd0);
    chk("aw_ready_in_reset1", 64'(aw_ready[1]), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_aw_ready",   64'(aw_ready[u]),   64'd1);
      chk("rst_w_ready",    64'(w_ready[u]),    64'd0);
      chk("rst_b_valid",    64'(b_valid[u]),    64'd0);
      chk("rst_b_resp",     64'(b_resp[u]),     64'd0);
      chk("rst_cap_valid",  64'(cap_valid[u]),  64'd0);
      chk("rst_cap_base",   cap_base[u],        64'd0);
      chk("rst_cap_beats",  64'(cap_beats[u]),  64'd0);
      chk("rst_dump_count", 64'(dump_count[u]), 64'd0);
      chk("rst_rd_data",    rd_data[u],         64'd0);
    end

    // Nominal six-beat dump, no stall.
    issue(0, 64'h1000, 32'd384, 6, 6, 2'b00, 0, 1'b0);
    @(negedge clk);
    chk("nom_cap_valid",  64'(cap_valid[0]),  64'd1);
    chk("nom_cap_beats",  64'(cap_beats[0]),  64'd6);
    chk("nom_dump_count", 64'(dump_count[0]), 64'd1);
    chk("nom_cap_base",   cap_base[0],        64'h1000);
    chk("nom_aw_ready",   64'(aw_ready[0]),   64'd1);
    rd_check(0, 6'd9,  64'h0000_0001_0000_0001, "nom_rd9");
    rd_check(0, 6'd48, 64'h0,                   "nom_rd48");
    rd_check(0, 6'd47, 64'h0000_0005_0000_0007, "nom_rd47");
    rd_check(0, 6'd0,  64'h0,                   "nom_rd0");

    // Two-cycle stall responder with initiator gaps.
    issue(1, 64'h2000, 32'd384, 6, 6, 2'b00, 1, 1'b1);
    @(negedge clk);
    chk("stall_cap_beats",  64'(cap_beats[1]),  64'd6);
    chk("stall_dump_count", 64'(dump_count[1]), 64'd1);
    rd_check(1, 6'd42, 64'h0001_0005_0000_0002, "stall_rd42");
    rd_check(1, 6'd3,  64'h0001_0000_0000_0003, "stall_rd3");

    // Oversize: ten beats, two discarded.
    issue(0, 64'h3000, 32'd640, 10, 10, 2'b10, 2, 1'b0);
    @(negedge clk);
    chk("over_cap_beats",  64'(cap_beats[0]),  64'd8);
    chk("over_dump_count", 64'(dump_count[0]), 64'd2);
    rd_check(0, 6'd63, 64'h0002_0007_0000_0007, "over_rd63");
    rd_check(0, 6'd0,  64'h0002_0000_0000_0000, "over_rd0");
    rd_check(0, 6'd8,  64'h0002_0001_0000_0000, "over_rd8");

    // Zero-length request.
    issue(0, 64'h4000, 32'd0, 0, 0, 2'b10, 3, 1'b0);
    @(negedge clk);
    chk("zero_w_ready",    64'(w_ready[0]),    64'd0);
    chk("zero_cap_valid",  64'(cap_valid[0]),  64'd1);
    chk("zero_cap_beats",  64'(cap_beats[0]),  64'd0);
    chk("zero_dump_count", 64'(dump_count[0]), 64'd3);
    chk("zero_cap_base",   cap_base[0],        64'h4000);
    rd_check(0, 6'd0, 64'h0, "zero_rd0");

    // Unaligned size: rounds up to two beats and flags an error.
    issue(0, 64'h4800, 32'd100, 2, 2, 2'b10, 4, 1'b1);
    @(negedge clk);
    chk("unal_cap_beats",  64'(cap_beats[0]),  64'd2);
    chk("unal_dump_count", 64'(dump_count[0]), 64'd4);
    rd_check(0, 6'd9, 64'h0004_0001_0000_0001, "unal_rd9");

    // cap_clear coincident with RESP loses to the completion set.
    issue(1, 64'h5000, 32'd64, 1, 1, 2'b00, 5, 1'b0);
    cap_clear[1] = 1'b1;
    @(negedge clk);
    cap_clear[1] = 1'b0;
    chk("clr_resp_cap_valid", 64'(cap_valid[1]),  64'd1);
    chk("clr_resp_dump",      64'(dump_count[1]), 64'd2);
    cap_clear[1] = 1'b1;
    @(negedge clk);
    cap_clear[1] = 1'b0;
    chk("clr_idle_cap_valid", 64'(cap_valid[1]), 64'd0);

    // Reset after three beats of a six-beat burst.
    issue(0, 64'h6000, 32'd384, 3, 6, 2'b00, 6, 1'b0);
    chk("mid_cap_valid_cleared", 64'(cap_valid[0]), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_dump_count", 64'(dump_count[0]), 64'd0);
    chk("mid_cap_valid",  64'(cap_valid[0]),  64'd0);
    chk("mid_w_ready",    64'(w_ready[0]),    64'd0);
    chk("mid_aw_ready",   64'(aw_ready[0]),   64'd1);
    chk("mid_cap_base",   cap_base[0],        64'd0);

    repeat (4) @(negedge clk);
    chk("sb_drain0", 64'(q0.size()), 64'd0);
    chk("sb_drain1", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_dump_responder.md
# pc_dump_responder

Write-side responder for the performance-counter dump channel. It accepts the address request and the multi-beat 512-bit write burst issued by the performance-counter unit, and stores the beats in an on-chip capture buffer. After the last beat it returns a single-cycle write response (b_valid), which the initiator waits on before signalling done. The captured counters are exposed on a 64-bit word read port for host/debug readback, and the block doubles as the bench-side sink for the dump path.

## Interface
- DATA_WIDTH, 512: write beat width (bits); BYTES_PER_BEAT = DATA_WIDTH/8
- ADDR_WIDTH, 64: address width
- SIZE_WIDTH, 32: byte-count width of aw_size
- MAX_BEATS, 8: capture buffer depth in beats
- WORD_WIDTH, 64: readback word width; WPB = DATA_WIDTH/WORD_WIDTH
- WREADY_STALL, 0: cycles w_ready is forced low after each accepted beat
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- aw_valid  in  1  address request valid
- aw_addr  in  ADDR_WIDTH  destination address
- aw_size  in  SIZE_WIDTH  burst length in bytes
- aw_ready  out  1  address accepted
- w_valid  in  1  write beat valid
- w_data  in  DATA_WIDTH  write beat
- w_ready  out  1  beat accepted when w_valid && w_ready
- b_valid  out  1  write response, exactly one cycle
- b_resp  out  2  2'b00 OKAY, 2'b10 SLVERR
- cap_valid  out  1  a completed capture is held in the buffer
- cap_base  out  ADDR_WIDTH  aw_addr of the last accepted request
- cap_beats  out  $clog2(MAX_BEATS)+1  number of beats stored
- cap_clear  in  1  clears cap_valid
- dump_count  out  32  completed bursts; wraps at 2^32
- rd_idx  in  $clog2(MAX_BEATS*WPB)  word index = beat*WPB + j; j=0 selects bits [WORD_WIDTH-1:0] of the beat
- rd_data  out  WORD_WIDTH  registered read data

## Operation
- States: IDLE, DATA, STALL, RESP.
- **IDLE**
  - aw_ready=1, w_ready=0.
  - On aw_valid: latch aw_addr into cap_base, clear cap_valid, reset beat_idx to 0.
  - exp_beats = ceil(aw_size/BYTES_PER_BEAT).
  - err is set if aw_size==0, aw_size%BYTES_PER_BEAT!=0, or exp_beats>MAX_BEATS.
  - aw_size==0 -> RESP (no data phase). Otherwise -> DATA.
- **DATA**
  - w_ready=1.
  - On a beat: store w_data at buffer[beat_idx] only if beat_idx<MAX_BEATS; overflow beats are accepted and discarded. Then beat_idx++.
  - If this beat is beat exp_beats-1 -> RESP; else if WREADY_STALL>0 -> STALL; else stay in DATA.
- **STALL**: w_ready=0 for exactly WREADY_STALL cycles, then -> DATA.
- **RESP**
  - b_valid=1 and b_resp = err ? 2'b10 : 2'b00, for one cycle only (no b_ready).
  - At the end of the cycle: cap_valid<=1, cap_beats<=min(exp_beats,MAX_BEATS), dump_count++.
  - Next state IDLE.
- **cap_clear**: clears cap_valid in any state. If asserted in the RESP cycle, the RESP set takes priority.
- **Readback**: rd_data <= buffer word if (rd_idx/WPB)<cap_beats, else 0. Buffer storage is not reset.
- exp_beats and beat_idx are SIZE_WIDTH bits wide; there is no wrap within a burst.
- aw_valid outside IDLE is ignored (aw_ready=0). w_valid outside DATA is ignored.

## Timing
- Reset values:
  - aw_ready=0 during reset, then 1 from the first cycle after reset.
  - w_ready=0, b_valid=0, b_resp=0, cap_valid=0, cap_base=0, cap_beats=0, dump_count=0, rd_data=0.
  - State returns to IDLE.
- Reset mid-burst: discards the burst, issues no b_valid, and returns all outputs to their reset values.
- aw handshake at cycle T -> w_ready=1 at T+1.
- Last beat accepted at cycle L -> b_valid at L+1.
- cap_valid, cap_beats and dump_count are updated as of L+2. The next aw_ready is also at L+2.
- With WREADY_STALL=S: beat at cycle t -> w_ready low during t+1..t+S, high again at t+S+1.
- Minimum burst of N beats (S=0, w_valid held high): N+2 cycles from the aw handshake to b_valid, inclusive.
- rd_data latency: 1 cycle from rd_idx.

## Test plan
- **Reset check**: hold reset 3 cycles, release -> every output at its reset value; aw_ready=1 from the first cycle after release.
- **Nominal dump**: aw_addr=0x1000, aw_size=384, six beats with word j of beat k = {k,j}, w_valid held high -> beats accepted back-to-back, single b_valid with b_resp=0 one cycle after beat 5, cap_beats=6, dump_count=1, rd_idx=9 returns {1,1}, rd_idx=48 returns 0.
- **Initiator gaps and stall**: w_valid toggling, WREADY_STALL=2, aw_size=384 -> w_ready low exactly 2 cycles after each beat, data stored in order, b_resp=0.
- **Oversize burst**: aw_size=640, MAX_BEATS=8 -> 10 beats accepted, beats 8-9 discarded, b_resp=2'b10, cap_beats=8.
- **Size 0**: aw_size=0 -> w_ready never asserted, b_valid at T+1 with 2'b10, cap_beats=0, dump_count increments.
- **Reset and clear edge cases**: reset after beat 3 of a 6-beat burst -> no b_valid, cap_valid=0, dump_count=0. In a separate run, cap_clear asserted in the RESP cycle -> cap_valid=1.
